result_misr_16b: RTL
====================

RESULT_MISR_16B -- requirements
Module: result_misr_16b

Interface
REQ-001 Parameter BITWIDTH, default 16: width of result stream and signature.
REQ-002 Parameter LATENCY, default 4: cycles discarded after start (pipeline flush of the upstream flopped harness).
REQ-003 Parameter POLY, default 16'hB400: MISR feedback tap mask over signature bits.
REQ-004 Parameter SEED, default 16'h0000: signature value loaded at reset and at every accepted start.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 start  input  1  single-cycle request to begin a capture run; honoured only in IDLE.
REQ-008 num_samples  input  16  number of result words compacted per run; sampled when start is accepted.
REQ-009 result  input  BITWIDTH  result word from the upstream flopped harness, one word per cycle.
REQ-010 busy  output  1  high in FLUSH and CAPTURE.
REQ-011 done  output  1  one-cycle pulse when the run completes.
REQ-012 signature  output  BITWIDTH  current MISR value; holds after done until the next accepted start.
REQ-013 sample_count  output  16  number of words compacted in the current or last run.

Function
REQ-014 FSM states SHALL be IDLE, FLUSH, CAPTURE, DONE.
REQ-015 IDLE + start=1: latch num_samples, load signature=SEED, clear sample_count and flush counter, go to FLUSH.
REQ-016 IDLE + start=0: hold all registers.
REQ-017 FLUSH: ignore result and count LATENCY cycles, then go to CAPTURE. If LATENCY=0, go to CAPTURE on the next cycle without discarding.
REQ-018 FLUSH exit when latched num_samples=0: go directly to DONE; signature stays SEED.
REQ-019 CAPTURE: every cycle update signature and increment sample_count.
REQ-020 Feedback bit fb = XOR-reduce(signature AND POLY).
REQ-021 Next signature = {signature[BITWIDTH-2:0], fb} XOR result.
REQ-022 CAPTURE exit: leave for DONE in the cycle where sample_count reaches the latched num_samples. Exactly num_samples words are compacted.
REQ-023 DONE: done=1 for exactly one cycle, then return to IDLE. signature and sample_count are frozen.
REQ-024 start asserted in FLUSH, CAPTURE or DONE: ignored, with no effect on the run and no queuing.
REQ-025 start in the cycle after DONE (IDLE): accepted normally. Back-to-back runs are separated by exactly one IDLE cycle.
REQ-026 sample_count: saturates at num_samples and never wraps. num_samples=16'hFFFF completes after 65535 words.
REQ-027 busy and done: never high in the same cycle.
REQ-028 Outputs: busy, done, signature and sample_count are registered outputs with no combinational path from inputs.
REQ-029 Run latency: start accepted at cycle T gives done=1 at cycle T+1+LATENCY+num_samples (for LATENCY>0).

Reset
REQ-030 rst=1 forces, on the next posedge: state=IDLE, signature=SEED, sample_count=0, busy=0, done=0, and clears the flush counter and latched num_samples.
REQ-031 rst has priority over start and over all in-progress FSM activity. Asserting it mid-FLUSH or mid-CAPTURE aborts the run with no done pulse.
REQ-032 First start accepted: the cycle after rst deasserts.

Verification
REQ-033 SEED=0, LATENCY=4, start with num_samples=1, result=16'h1234 on the capture cycle -> signature=16'h1234, sample_count=1, done pulses once, 6 cycles after start.
REQ-034 SEED=0, num_samples=2, result=16'h0001 on both capture cycles -> signature 16'h0001 after the first word, then 16'h0003; done=1 one cycle after the second word.
REQ-035 num_samples=0, start -> busy for LATENCY cycles, done pulse, signature=SEED, sample_count=0; no result word consumed.
REQ-036 start re-pulsed during CAPTURE with num_samples=5 -> run unaffected; sample_count=5 at done; exactly one done pulse.
REQ-037 rst=1 asserted at capture word 3 of 8 -> next cycle: state IDLE, signature=SEED, busy=0, no done. A new start then completes normally.
REQ-038 Two back-to-back runs (start in the IDLE cycle after done) with identical result streams -> identical signatures. Changing a single bit in the second stream -> signatures differ.

Source files
------------

// File: rtl/result_misr_16b.sv
// result_misr_16b: compacts a stream of result words into a MISR signature.
// A capture run is requested with start_i while idle. The first LATENCY words
// are discarded to flush the upstream flopped harness. The next num_samples_i
// words are then folded into the signature, and done_o pulses for one cycle.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        single-cycle run request, honoured only when idle
//   num_samples_i  words to compact, latched when start_i is accepted
//   result_i       result word from the upstream harness, one per cycle
//   busy_o         high while flushing or capturing
//   done_o         one-cycle pulse when a run completes
//   signature_o    current MISR value, held after done_o until the next start
//   sample_count_o words compacted in the current or last run
module result_misr_16b #(
  parameter int unsigned            BITWIDTH = 16,
  parameter int unsigned            LATENCY  = 4,
  parameter logic [BITWIDTH-1:0]    POLY     = 16'hB400,
  parameter logic [BITWIDTH-1:0]    SEED     = 16'h0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [15:0]         num_samples_i,
  input  logic [BITWIDTH-1:0] result_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [BITWIDTH-1:0] signature_o,
  output logic [15:0]         sample_count_o
);

  localparam int unsigned FlushW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // Value of the flush counter on the final discarded cycle.
  localparam logic [FlushW-1:0] FlushLast = FlushW'((LATENCY == 0) ? 0 : LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] sig_q, sig_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         num_q, num_d;
  logic [FlushW-1:0]   flush_q, flush_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fb;

  assign fb = ^(sig_q & POLY);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    flush_d = flush_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          num_d   = num_samples_i;
          sig_d   = SEED;
          cnt_d   = '0;
          flush_d = '0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        // With LATENCY == 0 a single cycle is still spent here, but nothing is discarded
        // because result_i is never looked at in this state.
        if ((LATENCY == 0) || (flush_q == FlushLast)) begin
          state_d = (num_q == 16'd0) ? StDone : StCapture;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      StCapture: begin
        sig_d = {sig_q[BITWIDTH-2:0], fb} ^ result_i;
        cnt_d = cnt_q + 16'd1;
        // Leaving on the word that reaches num_q keeps the count saturated at num_q.
        if (cnt_d == num_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Flag outputs are decoded from the next state so they can be flopped.
    busy_d = (state_d == StFlush) || (state_d == StCapture);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      flush_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign signature_o    = sig_q;
  assign sample_count_o = cnt_q;

endmodule
